// File: rtl/wb_pkg.sv
// wb_pkg: Wishbone cycle-type constants and slave state type shared by the SRAM arbiter.
// Contents:
//   CTI_*      - cycle type identifiers (classic, constant, incrementing, end-of-burst)
//   BTE_LINEAR - linear burst type extension
//   slave_state_e - SRAM slave FSM states
package wb_pkg;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } slave_state_e;
endpackage

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin owner selection for the Wishbone masters.
// Ports:
//   sys_clk, sys_rst_n - clock and asynchronous active-low reset
//   req   - per-master cycle request (m_cyc)
//   hold  - slave busy; ownership is frozen while set
//   grant - index of the current owner
module wb_rr_arbiter #(
  parameter  int NMASTERS = 2,
  localparam int GW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NMASTERS-1:0] req,
  input  logic                hold,
  output logic [GW-1:0]       grant
);
  logic [GW-1:0] grant_q, grant_d, cand;
  // Scan owner+N down to owner+1 so the nearest requester after the owner wins.
  always_comb begin
    grant_d = grant_q;
    cand = grant_q;
    if (!hold && !req[grant_q]) begin
      for (int i = NMASTERS; i >= 1; i--) begin
        cand = GW'((int'(grant_q) + i) % NMASTERS);
        if (req[cand]) grant_d = cand;
      end
    end
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) grant_q <= '0;
    else grant_q <= grant_d;
  end
  assign grant = grant_q;
endmodule

// File: rtl/wb_sram_arbiter.sv
// wb_sram_arbiter: multi-master Wishbone slave onto a single-port 32-bit SRAM.
// Ports:
//   sys_clk, sys_rst_n           - clock and asynchronous active-low reset
//   m_adr/m_dat_w/m_sel/m_cyc/
//   m_stb/m_we/m_cti/m_bte       - packed master requests, master i at slice i
//   m_dat_r                      - shared read data, zero outside ack cycles
//   m_ack/m_err                  - per-master responses, only the owner's bit can be set
//   grant                        - current owner index
//   err_count                    - saturating count of null-region errors
module wb_sram_arbiter
  import wb_pkg::*;
#(
  parameter  int          NMASTERS    = 2,
  parameter  int          DEPTH_LOG2  = 14,
  parameter  int          WAIT_STATES = 0,
  parameter  logic [31:0] NULL_WORDS  = 32'h0001_0000,
  localparam int          GW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [NMASTERS*30-1:0] m_adr,
  input  logic [NMASTERS*32-1:0] m_dat_w,
  input  logic [NMASTERS*4-1:0]  m_sel,
  input  logic [NMASTERS-1:0]    m_cyc,
  input  logic [NMASTERS-1:0]    m_stb,
  input  logic [NMASTERS-1:0]    m_we,
  input  logic [NMASTERS*3-1:0]  m_cti,
  input  logic [NMASTERS*2-1:0]  m_bte,
  output logic [31:0]            m_dat_r,
  output logic [NMASTERS-1:0]    m_ack,
  output logic [NMASTERS-1:0]    m_err,
  output logic [GW-1:0]          grant,
  output logic [15:0]            err_count
);
  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];
  slave_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ack_q, ack_d, err_q, err_d;
  logic [31:0] dat_q, dat_d;
  logic [15:0] err_count_q, err_count_d;
  logic [29:0] badr_q, badr_d;
  logic [29:0] adr, radr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        cyc, stb, we, req_ok, burst_ok, respond;
  wb_rr_arbiter #(.NMASTERS(NMASTERS)) u_arb (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req       (m_cyc),
    .hold      (state_q != ST_IDLE),
    .grant     (grant)
  );
  assign adr   = m_adr[grant*30 +: 30];
  assign dat_w = m_dat_w[grant*32 +: 32];
  assign sel   = m_sel[grant*4 +: 4];
  assign cti   = m_cti[grant*3 +: 3];
  assign bte   = m_bte[grant*2 +: 2];
  assign cyc   = m_cyc[grant];
  assign stb   = m_stb[grant];
  assign we    = m_we[grant];
  // Responses are registered, so the cycle carrying ack/err still shows the
  // terminated request; IDLE ignores it to avoid accepting it twice.
  always_comb begin
    req_ok = cyc && stb;
    burst_ok = (cti == CTI_INCR) && (bte == BTE_LINEAR);
    state_d = state_q;
    cnt_d = cnt_q;
    respond = 1'b0;
    radr = adr;
    case (state_q)
      ST_IDLE:
        if (req_ok && !ack_q && !err_q) begin
          if (WAIT_STATES == 0) respond = 1'b1;
          else begin
            state_d = ST_WAIT;
            cnt_d = 4'(WAIT_STATES - 1);
          end
        end
      ST_WAIT:
        if (!req_ok) state_d = ST_IDLE;
        else if (cnt_q == 4'd0) respond = 1'b1;
        else cnt_d = cnt_q - 4'd1;
      // The master still shows the word being acked; a non-INCR cti there
      // (normally 111) marks the last word, so no further ack is issued.
      ST_BURST:
        if (!req_ok || !burst_ok) state_d = ST_IDLE;
        else begin
          respond = 1'b1;
          radr = badr_q;
        end
      default: state_d = ST_IDLE;
    endcase
    err_d = respond && ({2'b00, radr} < NULL_WORDS);
    ack_d = respond && !err_d;
    dat_d = ack_d ? mem[radr[DEPTH_LOG2-1:0]] : '0;
    state_d = respond ? ((ack_d && burst_ok) ? ST_BURST : ST_IDLE) : state_d;
    badr_d = ack_d ? radr + 30'd1 : badr_q;
    err_count_d = (err_d && err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      dat_q       <= '0;
      err_count_q <= '0;
      badr_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      dat_q       <= dat_d;
      err_count_q <= err_count_d;
      badr_q      <= badr_d;
    end
  end
  // Writes commit at the end of the ack cycle using the word the master is
  // presenting then; in a burst that is exactly the word being acked.
  always_ff @(posedge sys_clk) begin
    if (ack_q && cyc && stb && we)
      for (int k = 0; k < 4; k++)
        if (sel[k]) mem[adr[DEPTH_LOG2-1:0]][8*k +: 8] <= dat_w[8*k +: 8];
  end
  always_comb begin
    m_ack = '0;
    m_err = '0;
    m_ack[grant] = ack_q;
    m_err[grant] = err_q;
  end
  assign m_dat_r   = dat_q;
  assign err_count = err_count_q;
endmodule

// File: tb/tb_wb_sram_arbiter.sv
// tb_wb_sram_arbiter: directed checks of the Wishbone SRAM arbiter (3 masters/2 wait states, and a zero-wait burst instance).
module tb_wb_sram_arbiter;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;
  logic [89:0] m_adr;
  logic [95:0] m_dat_w;
  logic [11:0] m_sel;
  logic [2:0]  m_cyc, m_stb, m_we;
  logic [8:0]  m_cti;
  logic [5:0]  m_bte;
  logic [31:0] m_dat_r;
  logic [2:0]  m_ack, m_err;
  logic [1:0]  grant;
  logic [15:0] err_count;
  logic [29:0] b_adr;
  logic [31:0] b_dat_w, b_dat_r;
  logic        b_cyc, b_stb, b_we, b_grant;
  logic [2:0]  b_cti;
  logic [1:0]  b_ack, b_err;
  logic [15:0] b_err_count;
  int checks = 0;
  int errors = 0;
  int both = 0;
  wb_sram_arbiter #(.NMASTERS(3), .WAIT_STATES(2)) u_dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .m_adr     (m_adr),
    .m_dat_w   (m_dat_w),
    .m_sel     (m_sel),
    .m_cyc     (m_cyc),
    .m_stb     (m_stb),
    .m_we      (m_we),
    .m_cti     (m_cti),
    .m_bte     (m_bte),
    .m_dat_r   (m_dat_r),
    .m_ack     (m_ack),
    .m_err     (m_err),
    .grant     (grant),
    .err_count (err_count)
  );
  wb_sram_arbiter #(.NMASTERS(2), .WAIT_STATES(0)) u_dut0 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .m_adr     ({30'd0, b_adr}),
    .m_dat_w   ({32'd0, b_dat_w}),
    .m_sel     ({4'd0, 4'hF}),
    .m_cyc     ({1'b0, b_cyc}),
    .m_stb     ({1'b0, b_stb}),
    .m_we      ({1'b0, b_we}),
    .m_cti     ({3'd0, b_cti}),
    .m_bte     (4'd0),
    .m_dat_r   (b_dat_r),
    .m_ack     (b_ack),
    .m_err     (b_err),
    .grant     (b_grant),
    .err_count (b_err_count)
  );
  always @(negedge sys_clk) if ((m_ack & m_err) != 3'b0 || (b_ack & b_err) != 2'b0) both++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic xfer(input int m, input logic we, input logic [29:0] a, input logic [31:0] d,
                      input logic [3:0] sel, output int lat, output logic [31:0] rd,
                      output logic ack, output logic err);
    m_adr[m*30 +: 30] = a;
    m_dat_w[m*32 +: 32] = d;
    m_sel[m*4 +: 4] = sel;
    m_we[m] = we;
    m_cyc[m] = 1'b1;
    m_stb[m] = 1'b1;
    lat = 0;
    ack = 1'b0;
    err = 1'b0;
    rd = '0;
    while (!ack && !err && lat < 20) begin
      @(posedge sys_clk); #1;
      lat++;
      ack = m_ack[m];
      err = m_err[m];
      rd = m_dat_r;
    end
    @(posedge sys_clk); #1;
    m_cyc[m] = 1'b0;
    m_stb[m] = 1'b0;
    m_we[m] = 1'b0;
  endtask
  task automatic wr0(input string tag, input logic [29:0] a, input logic [31:0] d, input logic [3:0] sel);
    int l;
    logic [31:0] r;
    logic k, e;
    xfer(0, 1'b1, a, d, sel, l, r, k, e);
    check({tag, "_ack"}, k, 1);
    check({tag, "_lat"}, l, 3);
  endtask
  task automatic rd0(input string tag, input logic [29:0] a, input logic [31:0] exp);
    int l;
    logic [31:0] r;
    logic k, e;
    xfer(0, 1'b0, a, 32'h0, 4'hF, l, r, k, e);
    check({tag, "_ack"}, k, 1);
    check({tag, "_lat"}, l, 3);
    check({tag, "_dat"}, r, exp);
  endtask
  task automatic burst0(input logic we);
    int i, n;
    logic adv;
    i = 0;
    n = 0;
    adv = 1'b0;
    b_we = we;
    b_adr = 30'h0001_0000;
    b_dat_w = 32'hB000_0000;
    b_cti = 3'b010;
    b_cyc = 1'b1;
    b_stb = 1'b1;
    while (i < 4 && n < 20) begin
      @(posedge sys_clk); #1;
      n++;
      if (adv) begin
        b_adr = 30'h0001_0000 + 30'(i);
        b_dat_w = 32'hB000_0000 + 32'(i);
        b_cti = (i == 3) ? 3'b111 : 3'b010;
      end
      adv = b_ack[0];
      if (adv) begin
        check("burst_cycle", n, i + 1);
        if (!we) check("burst_data", b_dat_r, 32'hB000_0000 + i);
        i++;
      end
    end
    check("burst_acks", i, 4);
    @(posedge sys_clk); #1;
    check("burst_end", b_ack, 0);
    b_cyc = 1'b0;
    b_stb = 1'b0;
    b_we = 1'b0;
    b_cti = 3'b000;
  endtask
  initial begin
    int lat;
    logic [31:0] rd;
    logic ack, err, seen;
    int rr_exp[4] = '{0, 1, 2, 0};
    m_adr = '0; m_dat_w = '0; m_sel = '0; m_cyc = '0; m_stb = '0; m_we = '0; m_cti = '0; m_bte = '0;
    b_adr = '0; b_dat_w = '0; b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0; b_cti = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_resp", {m_ack, m_err}, 0);
    check("rst_dat", m_dat_r, 0);
    check("rst_errcnt", err_count, 0);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    wr0("ws2_wr", 30'h0001_0004, 32'hDEADBEEF, 4'hF);
    rd0("ws2_rd", 30'h0001_0004, 32'hDEADBEEF);
    wr0("lane_wr1", 30'h0001_0008, 32'h11223344, 4'hF);
    wr0("lane_wr2", 30'h0001_0008, 32'hAABBCCDD, 4'b0101);
    rd0("lane_rd", 30'h0001_0008, 32'h11BB33DD);
    wr0("sel0_wr", 30'h0001_0004, 32'h12345678, 4'h0);
    rd0("sel0_rd", 30'h0001_0004, 32'hDEADBEEF);
    wr0("alias_wr", 30'h0001_4004, 32'h55AA55AA, 4'hF);
    rd0("alias_rd", 30'h0001_0004, 32'h55AA55AA);
    wr0("null_pre", 30'h0001_0010, 32'h01020304, 4'hF);
    xfer(0, 1'b0, 30'h0000_0010, 32'h0, 4'hF, lat, rd, ack, err);
    check("null_rd_err", err, 1);
    check("null_rd_ack", ack, 0);
    check("null_rd_dat", rd, 0);
    check("null_rd_lat", lat, 3);
    check("null_cnt1", err_count, 1);
    xfer(0, 1'b1, 30'h0000_0010, 32'hCAFEF00D, 4'hF, lat, rd, ack, err);
    check("null_wr_err", err, 1);
    check("null_cnt2", err_count, 2);
    rd0("null_keep", 30'h0001_0010, 32'h01020304);
    wr0("drop_pre", 30'h0001_0060, 32'h2468ACE0, 4'hF);
    m_adr[29:0] = 30'h0001_0060;
    m_dat_w[31:0] = 32'hFFFF_FFFF;
    m_sel[3:0] = 4'hF;
    m_we[0] = 1'b1;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    @(posedge sys_clk); #1;
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    m_we[0] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge sys_clk); #1;
      seen |= |{m_ack, m_err};
    end
    check("drop_noack", seen, 0);
    rd0("drop_keep", 30'h0001_0060, 32'h2468ACE0);
    for (int m = 0; m < 3; m++) wr0("rr_pre", 30'h0001_0040 + 30'(m), 32'hA0 + m, 4'hF);
    for (int m = 0; m < 3; m++) begin
      m_adr[m*30 +: 30] = 30'h0001_0040 + 30'(m);
      m_sel[m*4 +: 4] = 4'hF;
      m_we[m] = 1'b0;
      m_cyc[m] = 1'b1;
      m_stb[m] = 1'b1;
    end
    for (int s = 0; s < 4; s++) begin
      for (int n = 0; n < 30 && m_ack == 3'b0; n++) begin
        @(posedge sys_clk); #1;
      end
      check("rr_grant", grant, rr_exp[s]);
      check("rr_ack", m_ack, 32'd1 << rr_exp[s]);
      check("rr_data", m_dat_r, 32'hA0 + rr_exp[s]);
      @(posedge sys_clk); #1;
      m_cyc[rr_exp[s]] = 1'b0;
      m_stb[rr_exp[s]] = 1'b0;
      if (s == 0) begin
        @(posedge sys_clk); #1;
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
      end
    end
    xfer(2, 1'b1, 30'h0001_0050, 32'h13579BDF, 4'hF, lat, rd, ack, err);
    check("rst_pre_ack", ack, 1);
    check("rst_pre_grant", grant, 2);
    m_adr[60 +: 30] = 30'h0001_0050;
    m_dat_w[64 +: 32] = 32'hFFFF_FFFF;
    m_we[2] = 1'b1;
    m_cyc[2] = 1'b1;
    m_stb[2] = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b0;
    #1;
    check("rst_async_grant", grant, 0);
    m_cyc[2] = 1'b0;
    m_stb[2] = 1'b0;
    m_we[2] = 1'b0;
    seen = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge sys_clk); #1;
      seen |= |{m_ack, m_err};
    end
    check("rst_noack", seen, 0);
    check("rst_grant_after", grant, 0);
    check("rst_errcnt_after", err_count, 0);
    rd0("rst_keep", 30'h0001_0050, 32'h13579BDF);
    burst0(1'b1);
    burst0(1'b0);
    check("burst_errcnt", b_err_count, 0);
    check("ack_err_excl", both, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_sram_arbiter.md
WB_SRAM_ARBITER -- requirements
Module: wb_sram_arbiter

Interface
REQ-001 SHALL have parameter NMASTERS, default 2: number of Wishbone masters (1..8).
REQ-002 SHALL have parameter DEPTH_LOG2, default 14: SRAM depth in 32-bit words.
REQ-003 SHALL have parameter WAIT_STATES, default 0: idle cycles before each first ack/err (0..15).
REQ-004 SHALL have parameter NULL_WORDS, default 32'h0001_0000: word addresses below this return err (0 disables).
REQ-005 SHALL have port sys_clk  in  1  single clock; every flop SHALL be on its rising edge.
REQ-006 SHALL have port sys_rst_n  in  1  reset, asynchronous and active-low.
REQ-007 SHALL have ports m_adr  in  NMASTERS*30, m_dat_w  in  NMASTERS*32, m_sel  in  NMASTERS*4, m_cyc/m_stb/m_we  in  NMASTERS each, m_cti  in  NMASTERS*3, m_bte  in  NMASTERS*2: packed master requests, master i at slice i.
REQ-008 SHALL have ports m_dat_r  out  32  shared read data; m_ack/m_err  out  NMASTERS each  per-master responses.
REQ-009 SHALL have ports grant  out  $clog2(NMASTERS) (min 1)  current owner; err_count  out  16  saturating err count.

Function
REQ-010 Arbiter SHALL be round-robin: grant held while the owner's m_cyc=1; on the cycle after owner's cyc=0, grant SHALL move to the first requester at index owner+1, owner+2, ... (wrapping); with no requester grant is unchanged.
REQ-011 Only the granted master's signals SHALL reach the slave; m_ack/m_err of non-granted masters SHALL be 0.
REQ-012 Slave FSM states SHALL be IDLE, WAIT, BURST; cyc&stb in IDLE enters WAIT (or responds directly if WAIT_STATES=0).
REQ-013 First ack/err SHALL assert WAIT_STATES+1 cycles after cyc&stb is sampled, for exactly one cycle in classic mode (cti=000 or 111).
REQ-014 If cti=010 and bte=00, after the first ack FSM SHALL enter BURST and ack every cycle while stb=1, prefetching word adr+1; cti=111 ack SHALL return FSM to IDLE.
REQ-015 bte other than 00 SHALL be treated as classic (one ack per request).
REQ-016 Read data SHALL be valid on m_dat_r in the same cycle as ack; m_dat_r SHALL be 0 when no ack.
REQ-017 Writes SHALL update only byte lanes with sel[k]=1, committed on the ack cycle; sel=0000 SHALL ack with no write.
REQ-018 SRAM index SHALL be adr[DEPTH_LOG2-1:0]; upper address bits alias (wrap).
REQ-019 Address < NULL_WORDS SHALL produce err instead of ack, suppress writes, end any burst, and increment err_count (saturating at 16'hFFFF).
REQ-020 ack and err SHALL never assert together.
REQ-021 Owner dropping cyc or stb during WAIT/BURST SHALL return FSM to IDLE next cycle with no ack and no write.
REQ-022 Grant change SHALL only occur when FSM is IDLE.

Reset
REQ-023 sys_rst_n=0 SHALL immediately force grant=0, FSM=IDLE, wait counter=0, m_ack=0, m_err=0, m_dat_r=0, err_count=0.
REQ-024 Reset mid-transaction SHALL drop the response without a write; SRAM contents SHALL not be cleared.
REQ-025 Outputs SHALL be valid from the first rising edge after reset release.

Structure
REQ-026 Shared package wb_pkg SHALL hold CTI (CLASSIC, CONST, INCR, END) and BTE (LINEAR) constants and the slave state enum.
REQ-027 Round-robin arbiter SHALL be sub-module wb_rr_arbiter (params NMASTERS; ports sys_clk, sys_rst_n, req, hold, grant).
REQ-028 SRAM SHALL be a plain inferred array in the top module, initialisable by simulation only.

Verification
REQ-029 WAIT_STATES=2, master 0 writes 32'hDEADBEEF sel=1111 to adr 30'h0001_0004, then reads it -> ack 3 cycles after stb each, read data 32'hDEADBEEF.
REQ-030 Write 32'h11223344 sel=1111, then 32'hAABBCCDD sel=0101 to the same address -> read returns 32'h11BB33DD.
REQ-031 NMASTERS=3, all cyc=1 continuously, each releasing after one access -> grant sequence 0,1,2,0; no cross-master ack.
REQ-032 Incrementing burst (cti=010 x3 then 111) from adr 30'h0001_0000, WAIT_STATES=0 -> 4 consecutive acks with words at indices 0..3 in order.
REQ-033 Read adr 30'h0000_0010 -> single err, no ack, err_count=1; write there leaves SRAM unchanged.
REQ-034 Assert sys_rst_n=0 during WAIT of a write -> ack never asserts, target word unchanged, grant=0 after release.
